// File: rtl/led_pkg.sv
// Shared constants for the LED driver: mode encodings, heartbeat slot width, address width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pkg;

    localparam int MODE_W    = 2;
    localparam int HB_SLOT_W = 5;   // heartbeat is decoded from the top 5 bits of hcnt

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_PWM     = 2'd1;
    localparam mode_t MODE_HB      = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

    // Channel index width; a single-channel build still gets a 1-bit address.
    function automatic int addr_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/led_driver_if.sv
// Register-file write bus into the LED driver (one channel write per cycle).
// Latency: n/a (wires only).
// Backpressure: none; the driver accepts every write.
// Ports/signals: wr_en strobe, wr_addr channel index, wr_mode, wr_duty.
interface led_driver_if import led_pkg::*; #(
    parameter int AW       = 2,
    parameter int PWM_BITS = 8
);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    mode_t               wr_mode;
    logic [PWM_BITS-1:0] wr_duty;

    modport master (output wr_en, wr_addr, wr_mode, wr_duty);
    modport slave  (input  wr_en, wr_addr, wr_mode, wr_duty);

endinterface

// File: rtl/led_channel.sv
// One LED channel: shadow/active mode+duty registers, PWM compare, mode mux, output flop.
// Latency: 1 cycle from shared counter state to pin; writes take effect at the next period wrap.
// Backpressure: none; writes always land in the shadow register.
// Ports: clk, reset (sync, active-high), wr (this channel selected), wr_mode, wr_duty,
//        commit (period wrap), pwm_cnt, hb, breathe_level (LED_DRIVER_BREATHE_EN only), out.
// Build option: LED_DRIVER_BREATHE_EN enables the triangle breathe mode.
module led_channel import led_pkg::*; #(
    parameter int PWM_BITS   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  mode_t               wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic                commit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                hb,
`ifdef LED_DRIVER_BREATHE_EN
    input  logic [PWM_BITS-1:0] breathe_level,
`endif
    output logic                out
);

    localparam logic POL = (ACTIVE_LOW != 0);

    mode_t               shadow_mode;
    mode_t               active_mode;
    logic [PWM_BITS-1:0] shadow_duty;
    logic [PWM_BITS-1:0] active_duty;
    logic                pwm_on;
    logic                raw;

    // The active pair only moves on the wrap edge, so a period is never cut short or
    // stretched by a mid-period write. A write on the wrap edge itself lands in the shadow
    // while the active pair picks up the previous shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mode <= MODE_OFF;
            shadow_duty <= '0;
            active_mode <= MODE_OFF;
            active_duty <= '0;
            out         <= POL;
        end else begin
            if (wr) begin
                shadow_mode <= wr_mode;
                shadow_duty <= wr_duty;
            end
            if (commit) begin
                active_mode <= shadow_mode;
                active_duty <= shadow_duty;
            end
            out <= raw ^ POL;
        end
    end

    // Duty of all-ones still leaves one dark cycle per period; full-on is intentionally absent.
    assign pwm_on = (pwm_cnt < active_duty);

    always_comb begin
        raw = 1'b0;
        case (active_mode)
            MODE_PWM:     raw = pwm_on;
            MODE_HB:      raw = hb & pwm_on;
`ifdef LED_DRIVER_BREATHE_EN
            MODE_BREATHE: raw = (pwm_cnt < breathe_level);
`else
            MODE_BREATHE: raw = pwm_on;
`endif
            default:      raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_driver.sv
// Multi-channel LED driver: shared PWM and heartbeat counters feeding CHANNELS led_channel slices.
// Latency: 1 cycle counter-to-pin; duty/mode writes become visible after the next PWM period wrap.
// Backpressure: none; one write per cycle is always accepted, out-of-range addresses are dropped.
// Ports: clk, reset (sync, active-high), bus (led_driver_if.slave write bus),
//        out[CHANNELS] LED pins, pwm_sync (high while pwm_cnt == 0), hb_beat (raw heartbeat).
// Build option: LED_DRIVER_BREATHE_EN makes mode 3 a triangle breathe; otherwise mode 3 == PWM.
module led_driver import led_pkg::*; #(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int HB_BITS    = 24,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    led_driver_if.slave         bus,
    output logic [CHANNELS-1:0] out,
    output logic                pwm_sync,
    output logic                hb_beat
);

    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [HB_BITS-1:0]   hcnt;
    logic                 pwm_wrap;
    logic [HB_SLOT_W-1:0] hb_slot;
    logic                 hb;
    logic [CHANNELS-1:0]  wr_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt  <= '0;
            hcnt     <= '0;
            pwm_sync <= 1'b0;
            hb_beat  <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            hcnt     <= hcnt + 1'b1;
            pwm_sync <= pwm_wrap;   // pwm_cnt is zero in the cycle this is high
            hb_beat  <= hb;
        end
    end

    // Commit edge: pwm_cnt about to roll from all-ones to zero.
    assign pwm_wrap = &pwm_cnt;

    // Double beat: slots 0 and 4 of 32.
    assign hb_slot = hcnt[HB_BITS-1 -: HB_SLOT_W];
    assign hb      = (hb_slot == HB_SLOT_W'(0)) || (hb_slot == HB_SLOT_W'(4));

`ifdef LED_DRIVER_BREATHE_EN
    // Triangle: the low PWM_BITS of the slice ramp up while its MSB is 0 and down while it is 1.
    logic [PWM_BITS:0]   breathe_t;
    logic [PWM_BITS-1:0] breathe_level;

    assign breathe_t     = hcnt[HB_BITS-6 -: PWM_BITS+1];
    assign breathe_level = breathe_t[PWM_BITS] ? ~breathe_t[PWM_BITS-1:0]
                                               : breathe_t[PWM_BITS-1:0];
`endif

    // Addresses at or above CHANNELS select nothing.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.wr_en && (int'(bus.wr_addr) == i)) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .wr            (wr_sel[g]),
            .wr_mode       (bus.wr_mode),
            .wr_duty       (bus.wr_duty),
            .commit        (pwm_wrap),
            .pwm_cnt       (pwm_cnt),
            .hb            (hb),
`ifdef LED_DRIVER_BREATHE_EN
            .breathe_level (breathe_level),
`endif
            .out           (out[g])
        );
    end

endmodule
